// File: rtl/mtimer.sv
`default_nettype none
// ============================================================================
//  Module   : mtimer
//  Purpose  : RISC-V machine timer. A 64-bit mtime counter with an 8-bit
//             style prescaler, a 64-bit mtimecmp register, and an active-low
//             level interrupt (ti) asserted while enabled and
//             mtime >= mtimecmp. Accessed over a 32-bit req/ack slave port.
//  Ports    : clk   - system clock, rising edge
//             rst   - asynchronous reset, active high
//             req   - 1-cycle access request
//             we    - 1 = write, 0 = read (sampled with req)
//             addr  - register byte offset (addr[1:0] ignored)
//             wdata - write data (sampled with req)
//             rdata - read data, valid while ack=1 on a read, else 0
//             ack   - access complete, exactly one cycle after req
//             ti    - timer interrupt, active low
//  Register map (byte offsets):
//             0x00 MTIME_LO  0x04 MTIME_HI (read = shadow latched by LO read)
//             0x08 CMP_LO    0x0C CMP_HI
//             0x10 CTRL  bit0 EN, bits[8+PRE_W-1:8] DIV
//             0x14 STAT  bit0 PEND (read only)
//  Revision : 1.0 - initial release
// ============================================================================
module mtimer #(
    parameter int PRE_W  = 8,   // prescaler width; must not exceed 24
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              ti
);

    localparam int IDX_W = ADDR_W - 2;

    localparam logic [IDX_W-1:0] c_IDX_MTIME_LO = IDX_W'(0);
    localparam logic [IDX_W-1:0] c_IDX_MTIME_HI = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_CMP_LO   = IDX_W'(2);
    localparam logic [IDX_W-1:0] c_IDX_CMP_HI   = IDX_W'(3);
    localparam logic [IDX_W-1:0] c_IDX_CTRL     = IDX_W'(4);
    localparam logic [IDX_W-1:0] c_IDX_STAT     = IDX_W'(5);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]      mtime_q,     mtime_d;
    logic [63:0]      mtimecmp_q,  mtimecmp_d;
    logic             en_q,        en_d;
    logic [PRE_W-1:0] div_q,       div_d;
    logic [PRE_W-1:0] pcnt_q,      pcnt_d;
    logic [31:0]      shadow_hi_q, shadow_hi_d;
    logic             ack_q,       ack_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic             ti_q,        ti_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_idx;
    logic             w_wr;
    logic             w_rd;
    logic             w_unused_addr;
    logic             w_pend;
    logic             w_tick;
    logic [31:0]      w_rdmux;

    assign w_idx         = addr[ADDR_W-1:2];
    assign w_unused_addr = ^addr[1:0];
    assign w_wr          = req & we;
    assign w_rd          = req & ~we;
    assign w_pend        = (mtime_q >= mtimecmp_q);
    // One mtime increment per (DIV+1) enabled cycles.
    assign w_tick        = en_q & (pcnt_q == div_q);

    // Read mux works on pre-edge values, so a read that coincides with an
    // increment returns the value before that increment.
    always_comb begin
        w_rdmux = '0;
        case (w_idx)
            c_IDX_MTIME_LO: w_rdmux = mtime_q[31:0];
            c_IDX_MTIME_HI: w_rdmux = shadow_hi_q;
            c_IDX_CMP_LO:   w_rdmux = mtimecmp_q[31:0];
            c_IDX_CMP_HI:   w_rdmux = mtimecmp_q[63:32];
            c_IDX_CTRL: begin
                w_rdmux[0]          = en_q;
                w_rdmux[8 +: PRE_W] = div_q;
            end
            c_IDX_STAT:     w_rdmux[0] = w_pend;
            default:        w_rdmux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        en_d        = en_q;
        div_d       = div_q;
        pcnt_d      = pcnt_q;
        shadow_hi_d = shadow_hi_q;
        ack_d       = req;
        rdata_d     = w_rd ? w_rdmux : 32'h0;
        ti_d        = ~(en_q & w_pend);

        if (w_tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (en_q) begin
            pcnt_d = w_tick ? '0 : pcnt_q + PRE_W'(1);
        end

        // A bus write to one half of mtime overrides the increment: the
        // other half keeps its pre-increment value, no carry is applied.
        if (w_wr) begin
            case (w_idx)
                c_IDX_MTIME_LO: mtime_d = {mtime_q[63:32], wdata};
                c_IDX_MTIME_HI: mtime_d = {wdata, mtime_q[31:0]};
                c_IDX_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], wdata};
                c_IDX_CMP_HI:   mtimecmp_d = {wdata, mtimecmp_q[31:0]};
                c_IDX_CTRL: begin
                    en_d   = wdata[0];
                    div_d  = wdata[8 +: PRE_W];
                    pcnt_d = '0;
                end
                default: ;
            endcase
        end

        // Reading the low word snapshots the high word so a LO-then-HI
        // read pair is coherent across a carry.
        if (w_rd && (w_idx == c_IDX_MTIME_LO)) begin
            shadow_hi_d = mtime_q[63:32];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q     <= 64'h0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q        <= 1'b0;
            div_q       <= '0;
            pcnt_q      <= '0;
            shadow_hi_q <= 32'h0;
            ack_q       <= 1'b0;
            rdata_q     <= 32'h0;
            ti_q        <= 1'b1;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            en_q        <= en_d;
            div_q       <= div_d;
            pcnt_q      <= pcnt_d;
            shadow_hi_q <= shadow_hi_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            ti_q        <= ti_d;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign ti    = ti_q;

endmodule
`default_nettype wire

// File: tb/tb_mtimer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mtimer
//  Purpose  : Self-checking bench for mtimer. Every bus access pushes its
//             expected rdata into a scoreboard queue; a monitor pops and
//             compares whenever ack is seen. Interrupt timing is checked
//             directly at cycle-exact points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mtimer;

    localparam logic [4:0] A_LO   = 5'h00;
    localparam logic [4:0] A_HI   = 5'h04;
    localparam logic [4:0] A_CLO  = 5'h08;
    localparam logic [4:0] A_CHI  = 5'h0C;
    localparam logic [4:0] A_CTRL = 5'h10;
    localparam logic [4:0] A_STAT = 5'h14;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        ti;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    mtimer #(.PRE_W(8), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .ti    (ti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges so far; at a falling edge the next sampling
    // edge is cyc+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a falling edge; holds req for exactly one rising edge.
    // Consecutive calls produce back-to-back requests.
    task automatic acc(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string tag);
        sb_t it;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        it.tag = tag;
        it.exp = w ? 32'h0 : e;
        sb.push_back(it);
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        acc(1'b1, a, d, 32'h0, "wr_ack");
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
        acc(1'b0, a, 32'h0, e, tag);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack) begin
                if (sb.size() == 0) begin
                    check("ack_without_req", 32'(ack), 32'h0);
                end else begin
                    sb_t it;
                    it = sb.pop_front();
                    check(it.tag, rdata, it.exp);
                end
            end else begin
                check("rdata_idle", rdata, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned e_d;
        int unsigned e_w;
        int unsigned e_h;
        logic [63:0] v;
        logic [31:0] lo_at;

        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_ack",   32'(ack), 32'h0);
        check("rst_rdata", rdata,    32'h0);
        check("rst_ti",    32'(ti),  32'h1);
        rst = 1'b0;

        rd(A_LO,   32'h0,         "rst_mtime_lo");
        rd(A_HI,   32'h0,         "rst_mtime_hi");
        rd(A_CLO,  32'hFFFF_FFFF, "rst_cmp_lo");
        rd(A_CHI,  32'hFFFF_FFFF, "rst_cmp_hi");
        rd(A_CTRL, 32'h0,         "rst_ctrl");
        rd(A_STAT, 32'h0,         "rst_stat");
        check("rst_ti_after", 32'(ti), 32'h1);

        // ---------------- prescaler DIV=3 ----------------
        wr(A_CTRL, 32'h0000_0301);
        repeat (39) @(negedge clk);
        rd(A_LO, 32'd9,  "div3_edge40");
        rd(A_LO, 32'd10, "div3_edge41");
        rd(A_CTRL, 32'h0000_0301, "ctrl_readback");

        // ---------------- shadow across 32-bit wrap ----------------
        wr(A_CTRL, 32'h0);
        wr(A_HI, 32'h0);
        wr(A_LO, 32'hFFFF_FFFE);
        e_d = cyc + 1;
        wr(A_CTRL, 32'h1);
        rd(A_LO, 32'hFFFF_FFFE, "wrap_lo_first");
        rd(A_HI, 32'h0,         "wrap_hi_shadow");
        repeat (4) @(negedge clk);
        rd(A_HI, 32'h0,         "wrap_hi_still_shadow");
        v = 64'hFFFF_FFFE + 64'(cyc - e_d);
        rd(A_LO, v[31:0],  "wrap_lo_second");
        rd(A_HI, v[63:32], "wrap_hi_carried");

        // ---------------- compare / interrupt timing ----------------
        wr(A_CTRL, 32'h0);
        wr(A_LO, 32'h0);
        wr(A_HI, 32'h0);
        wr(A_CHI, 32'hFFFF_FFFF);
        wr(A_CLO, 32'd20);
        wr(A_CHI, 32'h0);
        e_d = cyc + 1;
        wr(A_CTRL, 32'h1);
        repeat (19) @(negedge clk);
        rd(A_STAT, 32'h0, "stat_mtime19");
        check("ti_at_mtime20", 32'(ti), 32'h1);
        rd(A_STAT, 32'h1, "stat_mtime20");
        check("ti_one_cycle_later", 32'(ti), 32'h0);
        rd(A_CLO, 32'd20, "cmp_lo_readback");

        // ---------------- interrupt release ----------------
        wr(A_CLO, 32'd1000);
        check("ti_still_low_at_write", 32'(ti), 32'h0);
        @(negedge clk);
        check("ti_released_cmp", 32'(ti), 32'h1);
        wr(A_CLO, 32'h0);
        @(negedge clk);
        check("ti_low_again", 32'(ti), 32'h0);
        wr(A_CTRL, 32'h0);
        check("ti_low_at_disable", 32'(ti), 32'h0);
        @(negedge clk);
        check("ti_released_en", 32'(ti), 32'h1);
        rd(A_STAT, 32'h1, "stat_pend_en0");

        // ---------------- write beats increment ----------------
        wr(A_HI, 32'd7);
        wr(A_LO, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        e_w = cyc + 1;
        wr(A_LO, 32'd5);
        repeat (3) @(negedge clk);
        rd(A_LO, 32'd5 + (cyc - e_w), "lo_write_on_tick");
        rd(A_HI, 32'd7, "hi_no_carry");
        e_h   = cyc + 1;
        lo_at = 32'd5 + (e_h - e_w - 1);
        wr(A_HI, 32'd9);
        @(negedge clk);
        rd(A_LO, lo_at + (cyc - e_h), "lo_after_hi_write");
        rd(A_HI, 32'd9, "hi_write_on_tick");

        // ---------------- misc map ----------------
        rd(A_STAT + 5'h04, 32'h0, "unmapped_read");
        wr(5'h1C, 32'hDEAD_BEEF);
        wr(A_STAT, 32'h0);
        rd(A_STAT, 32'h1, "stat_ro");
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, 32'h0000_FF01, "ctrl_mask");
        rd(A_CHI, 32'h0, "cmp_hi_untouched");
        @(negedge clk);

        // ---------------- reset during access ----------------
        req  = 1'b1;
        we   = 1'b0;
        addr = A_CTRL;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("midrst_ack_before", 32'(ack), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_ack",   32'(ack), 32'h0);
        check("midrst_rdata", rdata,    32'h0);
        check("midrst_ti",    32'(ti),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        rd(A_LO,   32'h0,         "midrst_mtime_lo");
        rd(A_CTRL, 32'h0,         "midrst_ctrl");
        rd(A_CLO,  32'hFFFF_FFFF, "midrst_cmp_lo");
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
